// File: rtl/mod18_enable_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : mod18_enable_arbiter
// Purpose  : Round-robin time-slice arbiter sharing one external mod-MOD
//            counter among NREQ requesters; flags counter wrap events.
// Revision : 1.0 - initial release
// ============================================================================
module mod18_enable_arbiter #(
    parameter int NREQ    = 4,
    parameter int QUANTUM = 18,
    parameter int MOD     = 18,
    parameter int CW      = 5
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [NREQ-1:0]         req,
    output logic [NREQ-1:0]         gnt,
    output logic                    enable,
    input  logic [CW-1:0]           cnt,
    output logic [$clog2(NREQ)-1:0] owner_id,
    output logic                    busy,
    output logic                    slice_done,
    output logic                    wrap
);

    localparam int              c_iw      = $clog2(NREQ);
    localparam logic [1:0]      c_st_idle = 2'd0;
    localparam logic [1:0]      c_st_run  = 2'd1;
    localparam logic [1:0]      c_st_gap  = 2'd2;
    localparam logic [7:0]      c_quantum = 8'(QUANTUM);
    localparam logic [CW-1:0]   c_last    = CW'(MOD - 1);
    localparam logic [NREQ-1:0] c_one     = {{(NREQ-1){1'b0}}, 1'b1};
    localparam logic [c_iw-1:0] c_max_id  = c_iw'(NREQ - 1);

    logic [1:0]      r_state;
    logic [NREQ-1:0] r_gnt;
    logic [c_iw-1:0] r_owner;
    logic [c_iw-1:0] r_ptr;
    logic [7:0]      r_slice;
    logic            r_slice_done;

    logic            w_found;
    logic [c_iw-1:0] w_pick;
    int              w_idx;
    logic            w_exit;
    logic [c_iw-1:0] w_ptr_nxt;
    logic [NREQ-1:0] w_onehot;

    // Scan downward in offset so the closest set request above the pointer wins.
    always_comb begin
        w_found = 1'b0;
        w_pick  = '0;
        w_idx   = 0;
        for (int k = NREQ - 1; k >= 0; k--) begin
            w_idx = int'(r_ptr) + k;
            if (w_idx >= NREQ) begin
                w_idx = w_idx - NREQ;
            end
            if (req[w_idx]) begin
                w_found = 1'b1;
                w_pick  = c_iw'(w_idx);
            end
        end
    end

    // r_slice holds completed enable cycles, so +1 counts the current one.
    assign w_exit    = !req[r_owner] || ((r_slice + 8'd1) == c_quantum);
    assign w_ptr_nxt = (r_owner == c_max_id) ? '0 : r_owner + 1'b1;
    assign w_onehot  = c_one << w_pick;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= c_st_idle;
            r_gnt        <= '0;
            r_owner      <= '0;
            r_ptr        <= '0;
            r_slice      <= '0;
            r_slice_done <= 1'b0;
        end else begin
            r_slice_done <= 1'b0;
            case (r_state)
                c_st_idle, c_st_gap: begin
                    if (w_found) begin
                        r_gnt   <= w_onehot;
                        r_owner <= w_pick;
                        r_slice <= '0;
                        r_state <= c_st_run;
                    end else begin
                        r_state <= c_st_idle;
                    end
                end
                c_st_run: begin
                    if (w_exit) begin
                        r_gnt        <= '0;
                        r_ptr        <= w_ptr_nxt;
                        r_slice      <= '0;
                        r_slice_done <= 1'b1;
                        r_state      <= c_st_gap;
                    end else begin
                        r_slice <= r_slice + 8'd1;
                    end
                end
                default: begin
                    r_gnt   <= '0;
                    r_state <= c_st_idle;
                end
            endcase
        end
    end

    assign gnt        = r_gnt;
    assign enable     = |r_gnt;
    assign busy       = |r_gnt;
    assign owner_id   = r_owner;
    assign slice_done = r_slice_done;
    // Out-of-range counter values never match MOD-1, so faults stay silent.
    assign wrap       = enable && (cnt == c_last);

endmodule
`default_nettype wire

// File: tb/tb_mod18_enable_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_mod18_enable_arbiter
// Purpose  : Directed self-checking bench with a behavioural mod-18 counter.
// Revision : 1.0 - initial release
// ============================================================================
module tb_mod18_enable_arbiter;

    logic       clk = 1'b0;
    logic       rst;
    logic [3:0] req;
    logic [3:0] gnt;
    logic       enable;
    logic [4:0] cnt;
    logic [1:0] owner_id;
    logic       busy;
    logic       slice_done;
    logic       wrap;

    logic       cnt_load;
    logic [4:0] cnt_val;

    int tests = 0;
    int fails = 0;

    mod18_enable_arbiter #(.NREQ(4), .QUANTUM(18), .MOD(18), .CW(5)) dut (
        .clk        (clk),
        .rst        (rst),
        .req        (req),
        .gnt        (gnt),
        .enable     (enable),
        .cnt        (cnt),
        .owner_id   (owner_id),
        .busy       (busy),
        .slice_done (slice_done),
        .wrap       (wrap)
    );

    always #5 clk = ~clk;

    // External shared counter
    always @(posedge clk) begin
        if (cnt_load)    cnt <= cnt_val;
        else if (enable) cnt <= (cnt == 5'd17) ? 5'd0 : cnt + 5'd1;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Entered at the negedge of the first enable cycle of a grant; returns at
    // the negedge of the cycle after the gap.
    task automatic expect_slice(input string tag, input logic [3:0] g, input int own,
                                input int len, input int wraps,
                                input int chg_at, input logic [3:0] chg_val);
        int n;
        int w;
        check({tag, ":gnt"}, 32'(gnt), 32'(g));
        check({tag, ":owner"}, 32'(owner_id), own);
        check({tag, ":busy"}, 32'(busy), 32'd1);
        n = 0;
        w = 0;
        while (enable === 1'b1 && n < 64) begin
            n++;
            if (wrap === 1'b1) w++;
            if (n == chg_at) req = chg_val;
            @(negedge clk);
        end
        check({tag, ":len"}, n, len);
        check({tag, ":wraps"}, w, wraps);
        check({tag, ":gap_done"}, 32'(slice_done), 32'd1);
        check({tag, ":gap_gnt"}, 32'(gnt), 32'd0);
        @(negedge clk);
    endtask

    initial begin
        rst      = 1'b1;
        req      = 4'b1111;
        cnt_load = 1'b1;
        cnt_val  = 5'd0;

        // Reset held with all requests pending
        repeat (3) begin
            @(negedge clk);
            check("rst:gnt", 32'(gnt), 32'd0);
            check("rst:enable", 32'(enable), 32'd0);
            check("rst:done", 32'(slice_done), 32'd0);
            check("rst:owner", 32'(owner_id), 32'd0);
        end
        rst      = 1'b0;
        cnt_load = 1'b0;
        @(negedge clk);

        // Full rotation with all requests held
        expect_slice("rr0", 4'b0001, 0, 18, 1, 0, 4'b0000);
        expect_slice("rr1", 4'b0010, 1, 18, 1, 0, 4'b0000);
        expect_slice("rr2", 4'b0100, 2, 18, 1, 0, 4'b0000);
        expect_slice("rr3", 4'b1000, 3, 18, 1, 0, 4'b0000);
        expect_slice("rr4", 4'b0001, 0, 18, 1, 0, 4'b0000);

        // Owner 1 releases during its 5th enable cycle
        expect_slice("drop1", 4'b0010, 1, 5, 0, 5, 4'b1101);

        // Reset in enable cycle 7 of owner 2
        check("abort:gnt0", 32'(gnt), 32'b0100);
        repeat (6) @(negedge clk);
        check("abort:en7", 32'(enable), 32'd1);
        rst      = 1'b1;
        cnt_load = 1'b1;
        cnt_val  = 5'd0;
        req      = 4'b1010;
        @(negedge clk);
        check("abort:gnt", 32'(gnt), 32'd0);
        check("abort:enable", 32'(enable), 32'd0);
        check("abort:busy", 32'(busy), 32'd0);
        check("abort:done", 32'(slice_done), 32'd0);
        check("abort:owner", 32'(owner_id), 32'd0);
        rst      = 1'b0;
        cnt_load = 1'b0;
        @(negedge clk);
        req = 4'b0110;
        expect_slice("post_rst", 4'b0010, 1, 18, 1, 0, 4'b0000);

        // Owner 2 not preempted by req[0]; req[3] idle
        expect_slice("nopre", 4'b0100, 2, 18, 1, 3, 4'b0101);

        // Owner 0 releases in its first cycle: single enable cycle
        req = 4'b0100;
        expect_slice("one", 4'b0001, 0, 1, 0, 0, 4'b0000);

        // Lone requester gets back-to-back grants separated by one gap
        expect_slice("solo", 4'b0100, 2, 18, 1, 0, 4'b0000);
        req = 4'b0000;
        expect_slice("solo2", 4'b0100, 2, 1, 0, 0, 4'b0000);
        check("idle:gnt", 32'(gnt), 32'd0);
        check("idle:done", 32'(slice_done), 32'd0);
        check("idle:busy", 32'(busy), 32'd0);

        // wrap qualification and counter fault value
        cnt_load = 1'b1;
        cnt_val  = 5'd17;
        @(negedge clk);
        check("wrap:no_en", 32'(wrap), 32'd0);
        cnt_val = 5'd31;
        req     = 4'b0001;
        @(negedge clk);
        check("fault:enable", 32'(enable), 32'd1);
        check("fault:wrap", 32'(wrap), 32'd0);
        cnt_val = 5'd17;
        @(negedge clk);
        check("wrap:at17", 32'(wrap), 32'd1);
        cnt_load = 1'b0;
        req      = 4'b0000;
        repeat (3) @(negedge clk);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
`default_nettype wire
